// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmitter with input FIFO.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_t;

    // Parity bit for an already-masked data byte under the given mode.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered flags, level count and sticky overflow.
module uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    input  logic                    i_ovf_clr,
    output logic [WIDTH-1:0]        o_rd_data_c,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    // Qualify requests against current flags and compute the next occupancy.
    always_comb begin
        w_push      = i_wr_en & ~r_full;
        w_pop       = i_rd_en & ~r_empty;
        w_drop      = i_wr_en & r_full;
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Data array has no reset so it can map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Sticky overflow; a drop on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are sent back to back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    input  logic                    ovf_clr,
    output logic                    uart_tx,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_shift;
    logic             r_par;
    logic             r_tx;
    logic             r_busy;

    logic [7:0]       w_rd_data;
    logic             w_empty;
    logic             w_pop_c;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .i_rd_en     (w_pop_c),
        .i_ovf_clr   (ovf_clr),
        .o_rd_data_c (w_rd_data),
        .o_full      (full),
        .o_empty     (w_empty),
        .o_level     (level),
        .o_overflow  (overflow)
    );

    // A new frame starts from IDLE, or straight out of the last STOP cycle.
    assign w_pop_c = ~w_empty & ((r_state == ST_IDLE) ||
                                 ((r_state == ST_STOP) && (r_cnt == '0)));

    // Frame sequencer; uart_tx and busy are updated together with the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_pop_c) begin
            r_state <= ST_START;
            r_cnt   <= BIT_LAST;
            r_idx   <= '0;
            r_shift <= w_rd_data;
            r_par   <= parity_bit(w_rd_data & DATA_MASK, PARITY);
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                ST_START: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DATA;
                        r_cnt   <= BIT_LAST;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == '0) begin
                        r_cnt <= BIT_LAST;
                        if (r_idx == IDX_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                r_state <= ST_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= ST_STOP;
                                r_cnt   <= STOP_LAST;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_PAR: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_STOP;
                        r_cnt   <= STOP_LAST;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;
    assign busy    = r_busy;
    assign empty   = w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: expected frames are queued on push and checked by a serial receiver.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] wr_en;
    logic [3:0] ovf_clr;
    logic [3:0] tx;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] busy;
    logic [3:0] ovf;
    logic [7:0] wr_data [4];
    logic [2:0] lvl [4];

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned t_a;
    int unsigned t_p;
    int unsigned t_x;
    int unsigned t_s;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .ovf_clr(ovf_clr[0]),
        .uart_tx(tx[0]), .full(full[0]), .empty(empty[0]), .level(lvl[0]), .busy(busy[0]),
        .overflow(ovf[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .ovf_clr(ovf_clr[1]),
        .uart_tx(tx[1]), .full(full[1]), .empty(empty[1]), .level(lvl[1]), .busy(busy[1]),
        .overflow(ovf[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .ovf_clr(ovf_clr[2]),
        .uart_tx(tx[2]), .full(full[2]), .empty(empty[2]), .level(lvl[2]), .busy(busy[2]),
        .overflow(ovf[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .ovf_clr(ovf_clr[3]),
        .uart_tx(tx[3]), .full(full[3]), .empty(empty[3]), .level(lvl[3]), .busy(busy[3]),
        .overflow(ovf[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int s);
        int n = 0;
        while (busy[s] && n < 200) begin
            tick(1);
            n++;
        end
        if (busy[s]) check_val("idle_timeout", 32'(busy[s]), 32'd0);
    endtask

    // Receive one frame on instance s, sampling each bit at its centre.
    task automatic rx_frame(input int s, input int dbits, input bit par_en, input int stops,
                            output int unsigned waited);
        logic [7:0] data;
        logic       pbit;
        exp_t       e;
        waited = 0;
        data   = '0;
        pbit   = 1'b0;
        while (tx[s] !== 1'b0 && waited < 100) begin
            tick(1);
            waited++;
        end
        if (tx[s] !== 1'b0) begin
            check_val("rx_start_timeout", 32'(tx[s]), 32'd0);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        tick(2);
        check_val("rx_start_bit", 32'(tx[s]), 32'd0);
        for (int i = 0; i < dbits; i++) begin
            tick(4);
            data[i] = tx[s];
        end
        if (par_en) begin
            tick(4);
            pbit = tx[s];
        end
        for (int k = 0; k < stops; k++) begin
            tick(4);
            check_val("rx_stop_bit", 32'(tx[s]), 32'd1);
        end
        if (sb.size() == 0) begin
            check_val("rx_unexpected_frame", 32'(data), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check_val("rx_data", 32'(data), 32'(e.data));
            if (par_en) check_val("rx_parity", 32'(pbit), 32'(e.par));
        end
    endtask

    // Push into an idle, empty instance and check the two-edge start latency.
    task automatic push_one(input int s, input logic [7:0] d, input logic [7:0] exp_d,
                            input logic exp_p, output int unsigned t_fall);
        sb.push_back(exp_t'{data: exp_d, par: exp_p});
        wr_data[s] = d;
        wr_en[s]   = 1'b1;
        tick(1);
        wr_en[s]   = 1'b0;
        check_val("lat_edge0_tx", 32'(tx[s]), 32'd1);
        check_val("push_level", 32'(lvl[s]), 32'd1);
        tick(1);
        check_val("lat_edge1_tx", 32'(tx[s]), 32'd0);
        t_fall = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned w;
        int          n;
        logic        seen_low;

        rstn    = 1'b0;
        wr_en   = '0;
        ovf_clr = '0;
        for (int i = 0; i < 4; i++) wr_data[i] = '0;

        tick(3);
        check_val("rst_tx", 32'(tx[0]), 32'd1);
        check_val("rst_busy", 32'(busy[0]), 32'd0);
        check_val("rst_empty", 32'(empty[0]), 32'd1);
        check_val("rst_full", 32'(full[0]), 32'd0);
        check_val("rst_level", 32'(lvl[0]), 32'd0);
        check_val("rst_ovf", 32'(ovf[0]), 32'd0);
        rstn = 1'b1;

        // 8N1 single byte pushed on the first edge after reset release
        push_one(0, 8'h55, 8'h55, 1'b0, t_s);
        rx_frame(0, 8, 1'b0, 1, w);
        wait_idle(0);
        check_val("busy_len_55", cyc - t_s, 32'd40);

        // Six back-to-back pushes: the sixth is dropped while full
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_data[0] = 8'(8'hA0 + i);
                    wr_en[0]   = 1'b1;
                    ovf_clr[0] = (i == 5);
                    if (i < 5) sb.push_back(exp_t'{data: 8'(8'hA0 + i), par: 1'b0});
                    tick(1);
                    if (i == 1) t_a = cyc;
                    if (i == 4) begin
                        check_val("burst_level4", 32'(lvl[0]), 32'd4);
                        check_val("burst_full", 32'(full[0]), 32'd1);
                        check_val("burst_ovf_pre", 32'(ovf[0]), 32'd0);
                    end
                    if (i == 5) begin
                        check_val("drop_ovf_vs_clr", 32'(ovf[0]), 32'd1);
                        check_val("drop_level", 32'(lvl[0]), 32'd4);
                    end
                end
                wr_en[0]   = 1'b0;
                ovf_clr[0] = 1'b0;
            end
            begin
                int unsigned g;
                for (int f = 0; f < 5; f++) begin
                    rx_frame(0, 8, 1'b0, 1, g);
                    if (f > 0) check_val("burst_gap", g, 32'd2);
                end
            end
        join
        wait_idle(0);
        check_val("burst_len", cyc - t_a, 32'd200);
        check_val("ovf_sticky", 32'(ovf[0]), 32'd1);
        ovf_clr[0] = 1'b1;
        tick(1);
        ovf_clr[0] = 1'b0;
        check_val("ovf_cleared", 32'(ovf[0]), 32'd0);

        // Push on the same edge as a pop while full
        fork
            begin
                int m;
                for (int i = 0; i < 5; i++) begin
                    wr_data[0] = 8'(8'hB0 + i);
                    wr_en[0]   = 1'b1;
                    sb.push_back(exp_t'{data: 8'(8'hB0 + i), par: 1'b0});
                    tick(1);
                    if (i == 1) t_p = cyc;
                end
                wr_en[0] = 1'b0;
                m = 0;
                while (cyc != t_p + 39 && m < 100) begin
                    tick(1);
                    m++;
                end
                check_val("pp_pre_level", 32'(lvl[0]), 32'd4);
                wr_data[0] = 8'hEE;
                wr_en[0]   = 1'b1;
                tick(1);
                wr_en[0]   = 1'b0;
                check_val("pp_level", 32'(lvl[0]), 32'd3);
                check_val("pp_ovf", 32'(ovf[0]), 32'd1);
                check_val("pp_next_start", 32'(tx[0]), 32'd0);
            end
            begin
                int unsigned g;
                for (int f = 0; f < 5; f++) begin
                    rx_frame(0, 8, 1'b0, 1, g);
                    if (f > 0) check_val("pp_gap", g, 32'd2);
                end
            end
        join
        wait_idle(0);
        check_val("drain_empty", 32'(empty[0]), 32'd1);
        check_val("drain_level", 32'(lvl[0]), 32'd0);
        ovf_clr[0] = 1'b1;
        tick(1);
        ovf_clr[0] = 1'b0;

        // Parity modes
        push_one(1, 8'h07, 8'h07, 1'b1, t_s);
        rx_frame(1, 8, 1'b1, 1, w);
        wait_idle(1);
        push_one(2, 8'h03, 8'h03, 1'b1, t_s);
        rx_frame(2, 8, 1'b1, 1, w);
        wait_idle(2);
        push_one(2, 8'h07, 8'h07, 1'b0, t_s);
        rx_frame(2, 8, 1'b1, 1, w);
        wait_idle(2);

        // 7 data bits, 2 stop bits, two frames back to back
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    wr_data[3] = 8'hFF;
                    wr_en[3]   = 1'b1;
                    sb.push_back(exp_t'{data: 8'h7F, par: 1'b0});
                    tick(1);
                end
                wr_en[3] = 1'b0;
            end
            begin
                int unsigned g;
                rx_frame(3, 7, 1'b0, 2, g);
                rx_frame(3, 7, 1'b0, 2, g);
                check_val("stop2_gap", g, 32'd2);
            end
        join
        wait_idle(3);

        // Reset during the third data bit with two entries still queued
        for (int i = 0; i < 3; i++) begin
            wr_data[0] = 8'h00;
            wr_en[0]   = 1'b1;
            tick(1);
            if (i == 1) t_x = cyc;
        end
        wr_en[0] = 1'b0;
        check_val("rst_pre_level", 32'(lvl[0]), 32'd2);
        n = 0;
        while (cyc != t_x + 14 && n < 100) begin
            tick(1);
            n++;
        end
        check_val("rst_pre_tx", 32'(tx[0]), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check_val("midrst_tx", 32'(tx[0]), 32'd1);
        check_val("midrst_level", 32'(lvl[0]), 32'd0);
        check_val("midrst_busy", 32'(busy[0]), 32'd0);
        check_val("midrst_empty", 32'(empty[0]), 32'd1);
        tick(2);
        rstn = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) seen_low = 1'b1;
        end
        check_val("postrst_no_frame", 32'(seen_low), 32'd0);
        check_val("postrst_level", 32'(lvl[0]), 32'd0);
        check_val("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, rstn, which is asynchronous and active-low.
REQ-002 Parameter CLKS_PER_BIT, default 868, SHALL set clocks per serial bit (legal range 2..65535).
REQ-003 Parameter DEPTH, default 16, SHALL set FIFO entries (power of two, legal range 2..256).
REQ-004 Parameter DATA_BITS, default 8, SHALL set data bits per frame (legal range 5..8).
REQ-005 Parameter PARITY, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-006 Parameter STOP_BITS, default 1, SHALL set stop bits per frame (legal values 1 or 2).
REQ-007 Ports SHALL be, one per line:
 clk  in  1  system clock
 rstn  in  1  async active-low reset
 wr_en  in  1  push request
 wr_data  in  8  byte; bits above DATA_BITS-1 ignored
 ovf_clr  in  1  clears overflow
 uart_tx  out  1  serial line, idle high
 full  out  1  FIFO full
 empty  out  1  FIFO empty
 level  out  $clog2(DEPTH)+1  FIFO occupancy
 busy  out  1  frame in progress
 overflow  out  1  sticky dropped-write flag

Function
REQ-008 Push: wr_en=1 and full=0 at a rising edge SHALL store wr_data.
REQ-009 A push while full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs on the same edge.
REQ-010 overflow SHALL stay set until ovf_clr=1; a simultaneous drop and ovf_clr SHALL leave overflow=1.
REQ-011 Pointers SHALL wrap modulo DEPTH; level SHALL equal DEPTH when full=1 and 0 when empty=1.
REQ-012 A simultaneous push and pop SHALL leave level unchanged.
REQ-013 The FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-014 IDLE: when empty=0, the FSM SHALL pop one entry and go to START on the same edge.
REQ-015 Each state SHALL hold its bit for exactly CLKS_PER_BIT cycles, timed by a down-counter.
REQ-016 START SHALL drive 0.
REQ-017 DATA SHALL drive DATA_BITS bits, LSB first.
REQ-018 PAR SHALL drive the XOR of the data bits for even parity and its inverse for odd; PAR SHALL be skipped when PARITY=0.
REQ-019 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 At the end of STOP the FSM SHALL go directly to START with a pop if empty=0, and to IDLE otherwise; there SHALL be no idle gap between frames.
REQ-021 Latency: a push at edge E into an empty FIFO with the FSM idle SHALL make uart_tx fall after edge E+1.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 uart_tx SHALL be registered and glitch-free.

Reset
REQ-024 rstn=0 SHALL immediately force uart_tx=1, busy=0, empty=1, full=0, level=0, overflow=0, and FSM=IDLE.
REQ-025 Reset mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-026 After reset release, the first push SHALL be accepted on the first rising edge.

Structure
REQ-027 Package uart_pkg SHALL hold the parity-mode constants and the FSM state type.
REQ-028 FIFO storage and pointers SHALL be a sub-module, uart_fifo, parametrised by DEPTH and width.
REQ-029 FIFO storage SHALL be inferable as registers or distributed RAM, with no reset on the data array.

Verification (CLKS_PER_BIT=4, DEPTH=4 unless stated)
REQ-030 8N1, push 0x55 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy high for exactly 40 cycles.
REQ-031 Six pushes on consecutive edges (A..F) -> F dropped, overflow=1, level=4 after the 5th push; A..E sent in 200 gap-free cycles; overflow stays 1 until ovf_clr is pulsed.
REQ-032 PARITY=1, push 0x07 -> parity bit 1; PARITY=2, push 0x03 -> parity bit 1; PARITY=2, push 0x07 -> parity bit 0.
REQ-033 DATA_BITS=7, STOP_BITS=2, push 0xFF -> 7 data bits of 1, then uart_tx high for 8 cycles; the next start bit follows immediately if the FIFO is non-empty.
REQ-034 rstn low during the 3rd data bit with 2 entries queued -> uart_tx=1 at once, level=0; after release no further frame is sent.
REQ-035 Push and pop on the same edge with level=4 -> push dropped, overflow=1, level=3 on the next cycle.
